axil_bus_demux: RTL and testbench

AXIL_BUS_DEMUX -- requirements
Module: axil_bus_demux

---
 rtl/axil_bus_demux_pkg.sv | 29 ++
 rtl/axil_addr_decode.sv | 30 +++
 rtl/axil_bus_demux.sv | 265 ++++++++++++++++++++++++++
 tb/tb_axil_bus_demux.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_bus_demux_pkg.sv
// axil_bus_demux_pkg
//   Shared definitions for the AXI-Lite 1:N demultiplexer: response codes,
//   write/read FSM state encodings and the decode index-width helper.
package axil_bus_demux_pkg;

  localparam int unsigned RESP_OKAY   = 0;
  localparam int unsigned RESP_SLVERR = 2;
  localparam int unsigned RESP_DECERR = 3;

  typedef enum logic [1:0] {
    W_IDLE,
    W_FWD,
    W_WAIT,
    W_BRESP
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_FWD,
    R_WAIT,
    R_DATA
  } rd_state_t;

  // Port-index width; a single port still needs a 1-bit index signal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axil_addr_decode.sv
// axil_addr_decode
//   Maps an address onto a downstream port index.
//   addr   : address to decode
//   index  : addr[SLOT_BITS +: idx_width(NUM_M)]
//   decerr : any address bit above the index field is set, or index >= NUM_M
module axil_addr_decode
  import axil_bus_demux_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_M      = 2,
  parameter int SLOT_BITS  = 4
) (
  input  logic [ADDR_WIDTH-1:0]       addr,
  output logic [idx_width(NUM_M)-1:0] index,
  output logic                        decerr
);

  localparam int IDX_W = idx_width(NUM_M);

  logic [ADDR_WIDTH-1:0] region;

  // The window number above the slot offset: out-of-range high bits and
  // an index past the last port both show up as region >= NUM_M.
  always_comb begin
    region = addr >> SLOT_BITS;
    index  = region[IDX_W-1:0];
    decerr = (region >= ADDR_WIDTH'(NUM_M));
  end

endmodule

// File: rtl/axil_bus_demux.sv
// axil_bus_demux
//   AXI-Lite 1:NUM_M demultiplexer. One upstream slave port (s0_axi_*) is
//   routed to NUM_M downstream master ports (m_axi_*), each owning a
//   2**SLOT_BITS byte window. Independent write and read FSMs, one
//   outstanding transaction each; undecodable addresses answer DECERR.
//   axi_aclk / axi_areset : clock, synchronous active-high reset
//   s0_axi_aw*/w*/b*      : upstream write address / data / response
//   s0_axi_ar*/r*         : upstream read address / data
//   m_axi_*               : downstream channels, port i at slice [i*W +: W]
module axil_bus_demux
  import axil_bus_demux_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RESP_WIDTH = 3,
  parameter int NUM_M      = 2,
  parameter int SLOT_BITS  = 4
) (
  input  logic                             axi_aclk,
  input  logic                             axi_areset,

  input  logic [ADDR_WIDTH-1:0]            s0_axi_awaddr,
  input  logic                             s0_axi_awvalid,
  output logic                             s0_axi_awready,
  input  logic [DATA_WIDTH-1:0]            s0_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]          s0_axi_wstrb,
  input  logic                             s0_axi_wvalid,
  output logic                             s0_axi_wready,
  output logic [RESP_WIDTH-1:0]            s0_axi_bresp,
  output logic                             s0_axi_bvalid,
  input  logic                             s0_axi_bready,
  input  logic [ADDR_WIDTH-1:0]            s0_axi_araddr,
  input  logic                             s0_axi_arvalid,
  output logic                             s0_axi_arready,
  output logic [DATA_WIDTH-1:0]            s0_axi_rdata,
  output logic [RESP_WIDTH-1:0]            s0_axi_rresp,
  output logic                             s0_axi_rvalid,
  input  logic                             s0_axi_rready,

  output logic [NUM_M*ADDR_WIDTH-1:0]      m_axi_awaddr,
  output logic [NUM_M-1:0]                 m_axi_awvalid,
  input  logic [NUM_M-1:0]                 m_axi_awready,
  output logic [NUM_M*DATA_WIDTH-1:0]      m_axi_wdata,
  output logic [NUM_M*(DATA_WIDTH/8)-1:0]  m_axi_wstrb,
  output logic [NUM_M-1:0]                 m_axi_wvalid,
  input  logic [NUM_M-1:0]                 m_axi_wready,
  input  logic [NUM_M*RESP_WIDTH-1:0]      m_axi_bresp,
  input  logic [NUM_M-1:0]                 m_axi_bvalid,
  output logic [NUM_M-1:0]                 m_axi_bready,
  output logic [NUM_M*ADDR_WIDTH-1:0]      m_axi_araddr,
  output logic [NUM_M-1:0]                 m_axi_arvalid,
  input  logic [NUM_M-1:0]                 m_axi_arready,
  input  logic [NUM_M*DATA_WIDTH-1:0]      m_axi_rdata,
  input  logic [NUM_M*RESP_WIDTH-1:0]      m_axi_rresp,
  input  logic [NUM_M-1:0]                 m_axi_rvalid,
  output logic [NUM_M-1:0]                 m_axi_rready
);

  localparam int IDX_W  = idx_width(NUM_M);
  localparam int STRB_W = DATA_WIDTH / 8;

  // ---------------------------------------------------------------- write
  wr_state_t             wr_state;
  logic                  aw_held, w_held;
  logic                  awready_q, wready_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic [IDX_W-1:0]      widx_q;
  logic [NUM_M-1:0]      m_awvalid_q, m_wvalid_q, m_bready_q;
  logic                  bvalid_q;
  logic [RESP_WIDTH-1:0] bresp_q;

  logic [IDX_W-1:0]      wr_idx;
  logic                  wr_err;

  // Decoding the held address: AW may arrive before, with or after W.
  axil_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_M      (NUM_M),
    .SLOT_BITS  (SLOT_BITS)
  ) u_wr_decode (
    .addr   (awaddr_q),
    .index  (wr_idx),
    .decerr (wr_err)
  );

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      wr_state    <= W_IDLE;
      aw_held     <= 1'b0;
      w_held      <= 1'b0;
      awready_q   <= 1'b1;
      wready_q    <= 1'b1;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      widx_q      <= '0;
      m_awvalid_q <= '0;
      m_wvalid_q  <= '0;
      m_bready_q  <= '0;
      bvalid_q    <= 1'b0;
      bresp_q     <= RESP_WIDTH'(RESP_OKAY);
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (awready_q && s0_axi_awvalid) begin
            awaddr_q  <= s0_axi_awaddr;
            aw_held   <= 1'b1;
            awready_q <= 1'b0;
          end
          if (wready_q && s0_axi_wvalid) begin
            wdata_q  <= s0_axi_wdata;
            wstrb_q  <= s0_axi_wstrb;
            w_held   <= 1'b1;
            wready_q <= 1'b0;
          end
          if (aw_held && w_held) begin
            if (wr_err) begin
              bresp_q  <= RESP_WIDTH'(RESP_DECERR);
              bvalid_q <= 1'b1;
              wr_state <= W_BRESP;
            end else begin
              widx_q              <= wr_idx;
              m_awvalid_q[wr_idx] <= 1'b1;
              m_wvalid_q[wr_idx]  <= 1'b1;
              wr_state            <= W_FWD;
            end
          end
        end
        W_FWD: begin
          // AW and W retire independently; move on once neither is pending.
          if (m_awvalid_q[widx_q] && m_axi_awready[widx_q])
            m_awvalid_q <= '0;
          if (m_wvalid_q[widx_q] && m_axi_wready[widx_q])
            m_wvalid_q <= '0;
          if ((!m_awvalid_q[widx_q] || m_axi_awready[widx_q]) &&
              (!m_wvalid_q[widx_q]  || m_axi_wready[widx_q])) begin
            m_bready_q[widx_q] <= 1'b1;
            wr_state           <= W_WAIT;
          end
        end
        W_WAIT: begin
          if (m_axi_bvalid[widx_q]) begin
            bresp_q    <= m_axi_bresp[int'(widx_q)*RESP_WIDTH +: RESP_WIDTH];
            m_bready_q <= '0;
            bvalid_q   <= 1'b1;
            wr_state   <= W_BRESP;
          end
        end
        W_BRESP: begin
          if (s0_axi_bready) begin
            bvalid_q  <= 1'b0;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            wr_state  <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  assign s0_axi_awready = awready_q;
  assign s0_axi_wready  = wready_q;
  assign s0_axi_bvalid  = bvalid_q;
  assign s0_axi_bresp   = bresp_q;
  assign m_axi_awaddr   = {NUM_M{awaddr_q}};
  assign m_axi_wdata    = {NUM_M{wdata_q}};
  assign m_axi_wstrb    = {NUM_M{wstrb_q}};
  assign m_axi_awvalid  = m_awvalid_q;
  assign m_axi_wvalid   = m_wvalid_q;
  assign m_axi_bready   = m_bready_q;

  // ----------------------------------------------------------------- read
  rd_state_t             rd_state;
  logic                  arready_q;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [IDX_W-1:0]      ridx_q;
  logic [NUM_M-1:0]      m_arvalid_q, m_rready_q;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [RESP_WIDTH-1:0] rresp_q;

  logic [IDX_W-1:0]      rd_idx;
  logic                  rd_err;

  axil_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_M      (NUM_M),
    .SLOT_BITS  (SLOT_BITS)
  ) u_rd_decode (
    .addr   (s0_axi_araddr),
    .index  (rd_idx),
    .decerr (rd_err)
  );

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      rd_state    <= R_IDLE;
      arready_q   <= 1'b1;
      araddr_q    <= '0;
      ridx_q      <= '0;
      m_arvalid_q <= '0;
      m_rready_q  <= '0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      rresp_q     <= RESP_WIDTH'(RESP_OKAY);
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (s0_axi_arvalid) begin
            arready_q <= 1'b0;
            araddr_q  <= s0_axi_araddr;
            if (rd_err) begin
              rdata_q  <= '0;
              rresp_q  <= RESP_WIDTH'(RESP_DECERR);
              rvalid_q <= 1'b1;
              rd_state <= R_DATA;
            end else begin
              ridx_q              <= rd_idx;
              m_arvalid_q[rd_idx] <= 1'b1;
              rd_state            <= R_FWD;
            end
          end
        end
        R_FWD: begin
          if (m_axi_arready[ridx_q]) begin
            m_arvalid_q        <= '0;
            m_rready_q[ridx_q] <= 1'b1;
            rd_state           <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (m_axi_rvalid[ridx_q]) begin
            rdata_q    <= m_axi_rdata[int'(ridx_q)*DATA_WIDTH +: DATA_WIDTH];
            rresp_q    <= m_axi_rresp[int'(ridx_q)*RESP_WIDTH +: RESP_WIDTH];
            m_rready_q <= '0;
            rvalid_q   <= 1'b1;
            rd_state   <= R_DATA;
          end
        end
        R_DATA: begin
          if (s0_axi_rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            rd_state  <= R_IDLE;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  assign s0_axi_arready = arready_q;
  assign s0_axi_rvalid  = rvalid_q;
  assign s0_axi_rdata   = rdata_q;
  assign s0_axi_rresp   = rresp_q;
  assign m_axi_araddr   = {NUM_M{araddr_q}};
  assign m_axi_arvalid  = m_arvalid_q;
  assign m_axi_rready   = m_rready_q;

endmodule

// File: tb/tb_axil_bus_demux.sv
module tb_axil_bus_demux;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int RW = 3;
  localparam int NM = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [AW-1:0]     s_awaddr;
  logic              s_awvalid, s_awready;
  logic [DW-1:0]     s_wdata;
  logic [DW/8-1:0]   s_wstrb;
  logic              s_wvalid, s_wready;
  logic [RW-1:0]     s_bresp;
  logic              s_bvalid, s_bready;
  logic [AW-1:0]     s_araddr;
  logic              s_arvalid, s_arready;
  logic [DW-1:0]     s_rdata;
  logic [RW-1:0]     s_rresp;
  logic              s_rvalid, s_rready;

  logic [NM*AW-1:0]     m_awaddr, m_araddr;
  logic [NM-1:0]        m_awvalid, m_awready, m_wvalid, m_wready;
  logic [NM*DW-1:0]     m_wdata, m_rdata;
  logic [NM*(DW/8)-1:0] m_wstrb;
  logic [NM*RW-1:0]     m_bresp, m_rresp;
  logic [NM-1:0]        m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;

  int checks = 0;
  int errors = 0;
  int aw_hs0 = 0, w_hs0 = 0, s_b_hs = 0;

  always #5 clk = ~clk;

  axil_bus_demux #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .RESP_WIDTH (RW),
    .NUM_M      (NM),
    .SLOT_BITS  (4)
  ) dut (
    .axi_aclk       (clk),
    .axi_areset     (rst),
    .s0_axi_awaddr  (s_awaddr),
    .s0_axi_awvalid (s_awvalid),
    .s0_axi_awready (s_awready),
    .s0_axi_wdata   (s_wdata),
    .s0_axi_wstrb   (s_wstrb),
    .s0_axi_wvalid  (s_wvalid),
    .s0_axi_wready  (s_wready),
    .s0_axi_bresp   (s_bresp),
    .s0_axi_bvalid  (s_bvalid),
    .s0_axi_bready  (s_bready),
    .s0_axi_araddr  (s_araddr),
    .s0_axi_arvalid (s_arvalid),
    .s0_axi_arready (s_arready),
    .s0_axi_rdata   (s_rdata),
    .s0_axi_rresp   (s_rresp),
    .s0_axi_rvalid  (s_rvalid),
    .s0_axi_rready  (s_rready),
    .m_axi_awaddr   (m_awaddr),
    .m_axi_awvalid  (m_awvalid),
    .m_axi_awready  (m_awready),
    .m_axi_wdata    (m_wdata),
    .m_axi_wstrb    (m_wstrb),
    .m_axi_wvalid   (m_wvalid),
    .m_axi_wready   (m_wready),
    .m_axi_bresp    (m_bresp),
    .m_axi_bvalid   (m_bvalid),
    .m_axi_bready   (m_bready),
    .m_axi_araddr   (m_araddr),
    .m_axi_arvalid  (m_arvalid),
    .m_axi_arready  (m_arready),
    .m_axi_rdata    (m_rdata),
    .m_axi_rresp    (m_rresp),
    .m_axi_rvalid   (m_rvalid),
    .m_axi_rready   (m_rready)
  );

  // Handshake monitors
  always @(posedge clk) begin
    if (m_awvalid[0] && m_awready[0]) aw_hs0++;
    if (m_wvalid[0] && m_wready[0])   w_hs0++;
    if (s_bvalid && s_bready)         s_b_hs++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  function automatic logic probe(input int which, input int p);
    case (which)
      0:       return m_awvalid[p];
      1:       return m_bready[p];
      2:       return s_bvalid;
      3:       return m_rready[p];
      4:       return s_rvalid;
      default: return m_arvalid[p];
    endcase
  endfunction

  // Bounded wait on a DUT signal; an expired budget is a failed check.
  task automatic wait_for(input int which, input int p, input string tag);
    int n = 0;
    while (!probe(which, p) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(probe(which, p)), 64'd1);
  endtask

  task automatic send_aw_w(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
    s_awaddr = a; s_awvalid = 1'b1;
    s_wdata = d;  s_wstrb = s; s_wvalid = 1'b1;
    tick(1);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
  endtask

  task automatic give_bresp(input int p, input logic [RW-1:0] r, input string tag);
    wait_for(1, p, tag);
    m_bvalid[p] = 1'b1;
    m_bresp[p*RW +: RW] = r;
    tick(1);
    m_bvalid = '0;
  endtask

  task automatic accept_b();
    s_bready = 1'b1;
    tick(1);
    s_bready = 1'b0;
  endtask

  int aw0, w0, b0;

  initial begin
    rst = 1'b1;
    s_awaddr = '0; s_awvalid = 0; s_wdata = '0; s_wstrb = '0; s_wvalid = 0;
    s_bready = 0; s_araddr = '0; s_arvalid = 0; s_rready = 0;
    m_awready = '0; m_wready = '0; m_bresp = '0; m_bvalid = '0;
    m_arready = '0; m_rdata = '0; m_rresp = '0; m_rvalid = '0;
    tick(3);

    // Reset state
    chk("rst_bvalid", 64'(s_bvalid), 64'd0);
    chk("rst_rvalid", 64'(s_rvalid), 64'd0);
    chk("rst_bresp", 64'(s_bresp), 64'd0);
    chk("rst_rresp", 64'(s_rresp), 64'd0);
    chk("rst_rdata", 64'(s_rdata), 64'd0);
    chk("rst_m_valids", 64'({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}), 64'd0);
    rst = 1'b0;
    tick(1);
    chk("rst_readies", 64'({s_awready, s_wready, s_arready}), 64'b111);

    // Write to port 0
    m_awready = 2'b11; m_wready = 2'b11;
    send_aw_w(8'h04, 32'd30, 4'hF);
    wait_for(0, 0, "w1_awvalid_wait");
    chk("w1_awvalid", 64'(m_awvalid), 64'b01);
    chk("w1_wvalid", 64'(m_wvalid), 64'b01);
    chk("w1_awaddr", 64'(m_awaddr[7:0]), 64'h04);
    chk("w1_wdata", 64'(m_wdata[31:0]), 64'd30);
    chk("w1_wstrb", 64'(m_wstrb[3:0]), 64'hF);
    give_bresp(0, 3'd0, "w1_bready_wait");
    wait_for(2, 0, "w1_bvalid_wait");
    chk("w1_bresp", 64'(s_bresp), 64'd0);
    accept_b();
    chk("w1_bvalid_drop", 64'(s_bvalid), 64'd0);

    // Write to port 1 with SLVERR pass-through
    send_aw_w(8'h14, 32'd37, 4'hF);
    wait_for(0, 1, "w2_awvalid_wait");
    chk("w2_awvalid", 64'(m_awvalid), 64'b10);
    chk("w2_awaddr", 64'(m_awaddr[15:8]), 64'h14);
    chk("w2_wdata", 64'(m_wdata[63:32]), 64'd37);
    wait_for(1, 1, "w2_bready_wait");
    chk("w2_bready", 64'(m_bready), 64'b10);
    give_bresp(1, 3'd2, "w2_bready_wait2");
    wait_for(2, 0, "w2_bvalid_wait");
    chk("w2_bresp", 64'(s_bresp), 64'd2);
    accept_b();

    // Write decode error
    send_aw_w(8'h24, 32'd5, 4'hF);
    chk("w3_no_awvalid", 64'({m_awvalid, m_wvalid}), 64'd0);
    tick(1);
    chk("w3_bvalid", 64'(s_bvalid), 64'd1);
    chk("w3_bresp", 64'(s_bresp), 64'd3);
    chk("w3_no_valid", 64'({m_awvalid, m_wvalid, m_bready}), 64'd0);
    accept_b();

    // W three cycles ahead of AW, awready held off
    aw0 = aw_hs0; w0 = w_hs0; b0 = s_b_hs;
    m_awready = 2'b00;
    s_wdata = 32'h55; s_wstrb = 4'h3; s_wvalid = 1'b1;
    tick(1);
    s_wvalid = 1'b0;
    chk("w4_wready_low", 64'({s_awready, s_wready}), 64'b10);
    tick(2);
    s_awaddr = 8'h08; s_awvalid = 1'b1;
    tick(1);
    s_awvalid = 1'b0;
    wait_for(0, 0, "w4_awvalid_wait");
    chk("w4_wvalid", 64'(m_wvalid), 64'b01);
    chk("w4_wdata", 64'(m_wdata[31:0]), 64'h55);
    chk("w4_wstrb", 64'(m_wstrb[3:0]), 64'h3);
    tick(1);
    chk("w4_w_retired", 64'({m_awvalid, m_wvalid}), 64'b0100);
    tick(4);
    m_awready = 2'b11;
    give_bresp(0, 3'd0, "w4_bready_wait");
    wait_for(2, 0, "w4_bvalid_wait");
    tick(2);
    chk("w4_bvalid_held", 64'(s_bvalid), 64'd1);
    accept_b();
    tick(2);
    chk("w4_aw_count", 64'(aw_hs0 - aw0), 64'd1);
    chk("w4_w_count", 64'(w_hs0 - w0), 64'd1);
    chk("w4_b_count", 64'(s_b_hs - b0), 64'd1);
    chk("w4_bvalid_gone", 64'(s_bvalid), 64'd0);

    // Read from port 1, slow response, stalled upstream
    m_arready = 2'b11;
    s_araddr = 8'h10; s_arvalid = 1'b1;
    tick(1);
    s_arvalid = 1'b0;
    chk("r1_arvalid", 64'(m_arvalid), 64'b10);
    chk("r1_araddr", 64'(m_araddr[15:8]), 64'h10);
    wait_for(3, 1, "r1_rready_wait");
    chk("r1_rready", 64'(m_rready), 64'b10);
    tick(3);
    m_rvalid[1] = 1'b1; m_rdata[63:32] = 32'h2A; m_rresp[5:3] = 3'd0;
    tick(1);
    m_rvalid = '0; m_rdata[63:32] = 32'hDEAD;
    wait_for(4, 0, "r1_rvalid_wait");
    chk("r1_rdata", 64'(s_rdata), 64'h2A);
    tick(3);
    chk("r1_rvalid_held", 64'(s_rvalid), 64'd1);
    chk("r1_rdata_held", 64'(s_rdata), 64'h2A);
    chk("r1_rresp", 64'(s_rresp), 64'd0);
    s_rready = 1'b1;
    tick(1);
    s_rready = 1'b0;
    chk("r1_rvalid_drop", 64'(s_rvalid), 64'd0);

    // Read decode error
    s_araddr = 8'h30; s_arvalid = 1'b1;
    tick(1);
    s_arvalid = 1'b0;
    chk("r2_rvalid", 64'(s_rvalid), 64'd1);
    chk("r2_rresp", 64'(s_rresp), 64'd3);
    chk("r2_rdata", 64'(s_rdata), 64'd0);
    chk("r2_no_arvalid", 64'(m_arvalid), 64'd0);
    s_rready = 1'b1;
    tick(1);
    s_rready = 1'b0;

    // Reset while waiting on port 0 response
    send_aw_w(8'h00, 32'h11, 4'hF);
    wait_for(1, 0, "w5_bready_wait");
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    m_bvalid[0] = 1'b1; m_bresp[2:0] = 3'd2;
    tick(1);
    chk("w5_bready_after_rst", 64'(m_bready), 64'd0);
    tick(2);
    chk("w5_no_bvalid", 64'(s_bvalid), 64'd0);
    chk("w5_readies", 64'({s_awready, s_wready}), 64'b11);
    m_bvalid = '0; m_bresp = '0;

    send_aw_w(8'h0C, 32'h77, 4'hF);
    wait_for(0, 0, "w6_awvalid_wait");
    chk("w6_awaddr", 64'(m_awaddr[7:0]), 64'h0C);
    chk("w6_wdata", 64'(m_wdata[31:0]), 64'h77);
    give_bresp(0, 3'd0, "w6_bready_wait");
    wait_for(2, 0, "w6_bvalid_wait");
    chk("w6_bresp", 64'(s_bresp), 64'd0);
    accept_b();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
